// File: rtl/pwl_activation_pipe.sv
// Piecewise-linear activation: a = tbl[i] + ((tbl[i+1]-tbl[i]) * frac) >>> FRAC_W.
// Latency 3 cycles from acceptance to out_valid; throughput one sample per cycle.
// Backpressure: one global enable freezes every stage while out_valid && !out_ready.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_ready/in_z   input stream of signed Q(INT_W).(FRAC_W) samples
//   out_valid/out_ready/out_a output stream of signed activations
//   tbl_we/tbl_addr/tbl_data table write port, never back-pressured
module pwl_activation_pipe #(
   parameter int DATA_W = 32,
   parameter int INT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_z,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   input  logic              tbl_we,
   input  logic [INT_W-1:0]  tbl_addr,
   input  logic [DATA_W-1:0] tbl_data
);

   localparam int FRAC_W = DATA_W - INT_W;
   localparam int DEPTH  = 1 << INT_W;
   localparam int DIFF_W = DATA_W + 1;
   localparam int PROD_W = DATA_W + 1 + FRAC_W;
   // Largest positive integer part: its upper neighbour is itself (flat segment).
   localparam logic [INT_W-1:0] ADDR_CLAMP = {1'b0, {(INT_W-1){1'b1}}};

   // ------------------------------------------------------------------
   // Sample table: no reset, two combinational read ports used by S2.
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] tbl_q [DEPTH];

   always_ff @(posedge clk) begin
      if (tbl_we) begin
         tbl_q[tbl_addr] <= tbl_data;
      end
   end

   // ------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------
   logic                     en;

   logic                     s1_vld_q,   s1_vld_d;
   logic [INT_W-1:0]         s1_addr_q,  s1_addr_d;
   logic [INT_W-1:0]         s1_naddr_q, s1_naddr_d;
   logic [FRAC_W-1:0]        s1_frac_q,  s1_frac_d;

   logic                     s2_vld_q,   s2_vld_d;
   logic [DATA_W-1:0]        s2_base_q,  s2_base_d;
   logic signed [DIFF_W-1:0] s2_diff_q,  s2_diff_d;
   logic [FRAC_W-1:0]        s2_frac_q,  s2_frac_d;

   logic                     s3_vld_q,   s3_vld_d;
   logic signed [DATA_W-1:0] s3_base_q,  s3_base_d;
   logic signed [PROD_W-1:0] s3_prod_q,  s3_prod_d;

   logic                     out_vld_q,  out_vld_d;
   logic [DATA_W-1:0]        out_a_q,    out_a_d;

   // Datapath intermediates
   logic [INT_W-1:0]         in_addr;
   logic [DATA_W-1:0]        rd_base;
   logic [DATA_W-1:0]        rd_next;
   logic signed [PROD_W-1:0] diff_ext;
   logic signed [PROD_W-1:0] frac_ext;
   logic signed [PROD_W-1:0] sum_full;
   logic [PROD_W-DATA_W-1:0] unused_sum_hi;

   // Output register is the only place a stall can originate.
   assign en        = !out_vld_q || out_ready;
   assign in_ready  = en;
   assign out_valid = out_vld_q;
   assign out_a     = out_a_q;

   assign in_addr = in_z[DATA_W-1:FRAC_W];
   assign rd_base = tbl_q[s1_addr_q];
   assign rd_next = tbl_q[s1_naddr_q];

   // diff is signed, frac is an unsigned fraction: zero-extend frac so the
   // signed product is exact at PROD_W bits.
   assign diff_ext = PROD_W'(s2_diff_q);
   assign frac_ext = $signed({{(PROD_W-FRAC_W){1'b0}}, s2_frac_q});

   // Arithmetic shift floors toward -inf. The result stays between base and
   // next, so the upper bits are pure sign extension and can be dropped.
   assign sum_full      = PROD_W'(s3_base_q) + (s3_prod_q >>> FRAC_W);
   assign unused_sum_hi = sum_full[PROD_W-1:DATA_W];

   always_comb begin
      s1_vld_d   = s1_vld_q;
      s1_addr_d  = s1_addr_q;
      s1_naddr_d = s1_naddr_q;
      s1_frac_d  = s1_frac_q;
      s2_vld_d   = s2_vld_q;
      s2_base_d  = s2_base_q;
      s2_diff_d  = s2_diff_q;
      s2_frac_d  = s2_frac_q;
      s3_vld_d   = s3_vld_q;
      s3_base_d  = s3_base_q;
      s3_prod_d  = s3_prod_q;
      out_vld_d  = out_vld_q;
      out_a_d    = out_a_q;

      if (en) begin
         // S1: split the sample into table index, neighbour index and fraction.
         // Index all-ones (-1) wraps naturally to 0.
         s1_vld_d   = in_valid;
         s1_addr_d  = in_addr;
         s1_naddr_d = (in_addr == ADDR_CLAMP) ? in_addr : in_addr + INT_W'(1);
         s1_frac_d  = in_z[FRAC_W-1:0];

         // S2: table read; no bypass, so a write on this edge is seen next cycle.
         s2_vld_d   = s1_vld_q;
         s2_base_d  = rd_base;
         s2_diff_d  = $signed({rd_next[DATA_W-1], rd_next})
                    - $signed({rd_base[DATA_W-1], rd_base});
         s2_frac_d  = s1_frac_q;

         // S3: slope times fraction.
         s3_vld_d   = s2_vld_q;
         s3_base_d  = s2_base_q;
         s3_prod_d  = diff_ext * frac_ext;

         // Output register.
         out_vld_d  = s3_vld_q;
         out_a_d    = sum_full[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q   <= 1'b0;
         s1_addr_q  <= '0;
         s1_naddr_q <= '0;
         s1_frac_q  <= '0;
         s2_vld_q   <= 1'b0;
         s2_base_q  <= '0;
         s2_diff_q  <= '0;
         s2_frac_q  <= '0;
         s3_vld_q   <= 1'b0;
         s3_base_q  <= '0;
         s3_prod_q  <= '0;
         out_vld_q  <= 1'b0;
         out_a_q    <= '0;
      end else begin
         s1_vld_q   <= s1_vld_d;
         s1_addr_q  <= s1_addr_d;
         s1_naddr_q <= s1_naddr_d;
         s1_frac_q  <= s1_frac_d;
         s2_vld_q   <= s2_vld_d;
         s2_base_q  <= s2_base_d;
         s2_diff_q  <= s2_diff_d;
         s2_frac_q  <= s2_frac_d;
         s3_vld_q   <= s3_vld_d;
         s3_base_q  <= s3_base_d;
         s3_prod_q  <= s3_prod_d;
         out_vld_q  <= out_vld_d;
         out_a_q    <= out_a_d;
      end
   end

endmodule

// File: tb/tb_pwl_activation_pipe.sv
// Self-checking bench for pwl_activation_pipe: directed table/boundary cases
// plus randomized streams scored against an arithmetic reference model.
// Inputs change 1ns after the rising edge; DUT outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_pwl_activation_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_z;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic        tbl_we;
   logic [7:0]  tbl_addr;
   logic [31:0] tbl_data;

   always #5 clk = ~clk;

   pwl_activation_pipe #(.DATA_W(32), .INT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_z     (in_z),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_a    (out_a),
      .tbl_we   (tbl_we),
      .tbl_addr (tbl_addr),
      .tbl_data (tbl_data)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          fires    = 0;
   logic        seen_vld;
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   int          mdl_tbl[256];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] ramp(input int k);
      return 32'(k) << 24;
   endfunction

   // Reference: interpolate between table points with wide integer arithmetic.
   function automatic logic [31:0] ref_act(input logic [31:0] z);
      int unsigned ai = z[31:24];
      int unsigned ni = (ai == 127) ? 127 : (ai + 1) % 256;
      longint b = mdl_tbl[ai];
      longint n = mdl_tbl[ni];
      longint f = longint'(z[23:0]);
      longint p = (n - b) * f;
      longint q = p >>> 24;            // floor(p / 2^24)
      return 32'(b + q);
   endfunction

   // One clock: score the output handshake, mirror table writes, and queue the
   // expected result for a sample accepted on the coming edge.
   task automatic cycle();
      @(negedge clk);
      seen_vld = out_valid;
      if (out_valid && out_ready) begin
         fires++;
         check("out_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("out_a", out_a, exp_q.pop_front());
         got_q.push_back(out_a);
      end
      if (tbl_we) mdl_tbl[tbl_addr] = tbl_data;
      if (rst) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(ref_act(in_z));
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      tbl_we = 1'b1; tbl_addr = 8'(a); tbl_data = d;
      cycle();
      tbl_we = 1'b0;
   endtask

   task automatic run_one(input string tag, input logic [31:0] z, input logic [31:0] exp);
      got_q.delete();
      in_valid = 1'b1; in_z = z;
      cycle();
      in_valid = 1'b0;
      repeat (5) cycle();
      check(tag, (got_q.size() == 0) ? 32'hDEAD_BEEF : got_q[$], exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          lat;
      logic [31:0] held;

      rst = 1'b1; in_valid = 1'b0; in_z = '0; out_ready = 1'b1;
      tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
      repeat (2) cycle();
      rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_a", out_a, 0);

      // Identity ramp table
      for (int k = 0; k < 256; k++) wr(k, ramp(k));

      // Latency of a lone sample, plus its value
      got_q.delete();
      in_valid = 1'b1; in_z = 32'h0280_0000;
      cycle();
      in_valid = 1'b0;
      lat = 0;
      do begin cycle(); lat++; end while (!seen_vld && lat < 10);
      check("latency", 32'(lat - 1), 3);
      repeat (2) cycle();
      check("ramp_2p5", (got_q.size() == 0) ? 32'hDEAD_BEEF : got_q[0], 32'h0280_0000);

      run_one("ramp_neg_half", 32'hFF80_0000, 32'hFF80_0000);
      run_one("clamp", 32'h7FFF_FFFF, 32'h7F00_0000);
      run_one("most_negative", 32'h8000_0000, 32'h8000_0000);

      // Rounding toward -inf
      wr(1, 32'hFFFF_FFFF);
      run_one("round_floor", 32'h0000_0001, 32'hFFFF_FFFF);
      run_one("round_zero", 32'h0000_0000, 32'h0000_0000);
      wr(1, ramp(1));

      // Backpressure: 4 accepted, stall 4 cycles with a 5th pending
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_z = $urandom;
         cycle();
      end
      check("bp_first_vld", 32'(out_valid), 1);
      held = out_a;
      in_z = $urandom;
      out_ready = 1'b0;
      #1;
      check("bp_in_ready", 32'(in_ready), 0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("bp_in_ready", 32'(in_ready), 0);
         check("bp_hold_a", out_a, held);
         check("bp_hold_vld", 32'(out_valid), 1);
      end
      out_ready = 1'b1;
      fires = 0;
      cycle();
      in_valid = 1'b0;
      repeat (4) cycle();
      check("bp_fires", 32'(fires), 5);
      repeat (3) cycle();

      // Write hazard: tbl[1] rewritten mid-stream
      got_q.delete();
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1; in_z = 32'h0100_0000;
         tbl_we = (i == 5); tbl_addr = 8'd1; tbl_data = 32'h1234_0000;
         cycle();
      end
      in_valid = 1'b0; tbl_we = 1'b0;
      repeat (6) cycle();
      check("hazard_count", 32'(got_q.size()), 12);
      check("hazard_first", (got_q.size() == 0) ? 32'hDEAD_BEEF : got_q[0], 32'h0100_0000);
      check("hazard_last", (got_q.size() == 0) ? 32'hDEAD_BEEF : got_q[$], 32'h1234_0000);
      wr(1, ramp(1));

      // Reset with 3 samples in flight; a table write during reset still lands
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_z = $urandom;
         cycle();
      end
      in_valid = 1'b0;
      rst = 1'b1; tbl_we = 1'b1; tbl_addr = 8'd3; tbl_data = 32'h0ABC_0000;
      cycle();
      rst = 1'b0; tbl_we = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 0);
      check("midrst_out_a", out_a, 0);
      got_q.delete();
      repeat (6) cycle();
      check("midrst_no_stale", 32'(got_q.size()), 0);
      run_one("rst_write_kept", 32'h0300_0000, 32'h0ABC_0000);
      wr(3, ramp(3));
      run_one("post_rst_ramp", 32'h0540_0000, 32'h0540_0000);

      // Random stream with live table writes (no stalls)
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_z     = $urandom;
         tbl_we   = ($urandom_range(0, 7) == 0);
         tbl_addr = 8'($urandom);
         tbl_data = $urandom;
         cycle();
      end
      tbl_we = 1'b0;

      // Random stream with random backpressure
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 1) != 0);
         in_z      = $urandom;
         out_ready = ($urandom_range(0, 1) != 0);
         cycle();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
      check("drain_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pwl_activation_pipe.md
# pwl_activation_pipe

Streaming, parametrised piecewise-linear activation unit for the NN datapath. It maps a signed fixed-point pre-activation `z` to an activation `a` by looking up two adjacent table points and linearly interpolating between them. The table is run-time loadable, the pipeline is 3 stages with valid/ready flow control, and it sits between a neuron's accumulator output and the next layer's input buffer.

## Interface
- `DATA_W`, 32: width of `z`, `a` and table entries; signed two's complement.
- `INT_W`, 8: integer bits of `z` (Q`INT_W`.`FRAC_W`); table depth is 2^`INT_W`.
- `FRAC_W`, `DATA_W-INT_W` (derived, not overridable): fraction bits of `z`.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_z` is valid.
- `in_ready`  out  1  unit accepts `in_z` this cycle.
- `in_z`  in  `DATA_W`  signed pre-activation.
- `out_valid`  out  1  `out_a` is valid.
- `out_ready`  in  1  consumer accepts `out_a` this cycle.
- `out_a`  out  `DATA_W`  signed activation.
- `tbl_we`  in  1  table write strobe.
- `tbl_addr`  in  `INT_W`  table write address.
- `tbl_data`  in  `DATA_W`  table write data (signed sample value).

## Operation
- Decomposition: `addr = in_z[DATA_W-1:FRAC_W]` (raw bits, unsigned index); `frac = in_z[FRAC_W-1:0]` (unsigned).
- Next point: `naddr = addr+1 mod 2^INT_W`, except `addr == 2^(INT_W-1)-1` (largest positive integer part), where `naddr = addr`. This clamp gives a flat segment. `addr` all-ones (−1) wraps to 0, which is correct.
- `base = tbl[addr]`, `next = tbl[naddr]`.
- `diff = next - base`, computed at `DATA_W+1` bits signed.
- `prod = diff * frac`, computed at `DATA_W+1+FRAC_W` bits signed.
- `a = base + (prod >>> FRAC_W)`. The shift is an arithmetic shift, so it rounds toward −∞.
- Result bound: the result always lies in `[min(base,next), max(base,next)]`. Truncation to `DATA_W` is therefore lossless, and no saturation logic is required.
- Table storage:
  - 2^`INT_W` × `DATA_W` registers with two combinational read ports.
  - Not cleared by `rst`; contents are undefined until written.
  - Software must load the table before streaming.
- Table writes: when `tbl_we` is high at an edge, `tbl[tbl_addr] <= tbl_data`. Writes are accepted regardless of stream state and are never back-pressured.
- Pipeline stages:
  - S1 registers `addr`, `naddr`, `frac`.
  - S2 reads the table and registers `base` and `diff`.
  - S3 registers `base` and `prod`.
  - The output register holds `out_a`.
  - Each stage carries a valid bit.
- Flow control:
  - Global enable `en = !out_valid || out_ready`.
  - All stages advance together when `en` is high; all hold when it is low.
  - `in_ready = en`, driven combinationally from `out_valid`/`out_ready`.
  - A sample is accepted on an edge where `in_valid && in_ready`.
- Ordering: outputs appear strictly in acceptance order. No sample is dropped or duplicated except on `rst`.

## Timing
- Reset (synchronous, `rst` high at an edge):
  - All stage valid bits and `out_valid` become 0.
  - `out_a` becomes 0, and all pipeline data registers become 0.
  - `in_ready` is therefore 1 in the first cycle after reset.
- Latency: a sample accepted at edge t presents `out_valid=1` with its result after edge t+3, when there is no stall.
- Throughput: one sample per cycle while `out_ready` stays high.
- Stall behaviour:
  - While `out_valid && !out_ready`, `out_a` and every stage hold their values.
  - `in_ready` is 0 during the stall.
  - `out_a` must not change while `out_valid` is high and the output has not been accepted.
- Write/read ordering:
  - A table read happens in S2.
  - A write at edge t is visible to an S2 read in the cycle after edge t.
  - An S2 read in the same cycle as the write sees the old value. No bypass is provided.
- Reset mid-stream: all in-flight samples are discarded and the table keeps its contents. Behaviour of `tbl_we` during `rst` is unaffected: the write is performed.

## Test plan
- Identity ramp: load `tbl[k] = sext(k)<<24` for k = 0..255. Drive `in_z=0x0280_0000` (2.5) → `out_a=0x0280_0000` after edge t+3. Drive `0xFF80_0000` (−0.5; addr 255 → naddr 0) → `0xFF80_0000`.
- Clamp: with the ramp table, drive `in_z=0x7FFF_FFFF` → `out_a=0x7F00_0000` (the `tbl[127]` value, flat segment).
- Rounding: set `tbl[0]=0`, `tbl[1]=-1`, and drive `in_z=0x0000_0001` → `prod=-1`, which floors to −1 → `out_a=0xFFFF_FFFF`. Drive `in_z=0` → `out_a=0`.
- Backpressure: stream 5 back-to-back samples with `out_ready=0` from the cycle the first output appears, for 4 cycles. Require:
  - `in_ready=0` throughout the stall.
  - `out_a` stable throughout the stall.
  - After release, all 5 results arrive in order, one per cycle, with none lost or duplicated.
- Write hazard: stream `in_z=0x0100_0000` continuously and write `tbl[1]=0x1234_0000` at edge w. Require:
  - Samples whose S2 cycle is at or before the write cycle use the old value.
  - All later samples return `0x1234_0000`.
- Reset mid-stream: with 3 samples in flight, assert `rst` for one edge. Require:
  - `out_valid=0` and `out_a=0` on the following cycle.
  - No stale result ever appears.
  - The table is intact, so the next sample after reset returns the correct ramp value.
